// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
//   Shared definitions for the LEGv8 multi-cycle controller: FSM state
//   encoding, instruction classes, immediate-format and ALU operation
//   codes, and the opcode patterns used by the controller and the sign
//   extender's format selection.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } mc_state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_LDUR    = 3'd1,
        CLS_STUR    = 3'd2,
        CLS_CBZ     = 3'd3,
        CLS_B       = 3'd4,
        CLS_RTYPE   = 3'd5
    } instr_class_e;

    localparam logic [1:0] IMM_D    = 2'b00;
    localparam logic [1:0] IMM_CB   = 2'b01;
    localparam logic [1:0] IMM_B    = 2'b10;
    localparam logic [1:0] IMM_NONE = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    // CBZ is matched on opcode[10:3], B on opcode[10:5]
    localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;
    localparam logic [5:0]  OP_B_HI   = 6'b000101;

    // Immediate format the sign extender applies for a given class
    function automatic logic [1:0] imm_format(input instr_class_e cls);
        logic [1:0] fmt;
        case (cls)
            CLS_LDUR, CLS_STUR: fmt = IMM_D;
            CLS_CBZ:            fmt = IMM_CB;
            CLS_B:              fmt = IMM_B;
            default:            fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/multicycle_control_opcode_classifier.sv
// opcode_classifier
//   Combinational decode of IR[31:21] into an instruction class and the
//   matching immediate format. Also used by the sign extender.
//   Ports:
//     opcode  in   11  IR[31:21]
//     cls     out  3   instruction class (CLS_ILLEGAL when unrecognised)
//     imm_sel out  2   immediate format for that class
module opcode_classifier
    import multicycle_control_pkg::*;
(
    input  logic [10:0]  opcode,
    output instr_class_e cls,
    output logic [1:0]   imm_sel
);

    // Priority match of the opcode patterns; patterns do not overlap
    always_comb begin
        cls = CLS_ILLEGAL;
        if (opcode == OP_LDUR) begin
            cls = CLS_LDUR;
        end else if (opcode == OP_STUR) begin
            cls = CLS_STUR;
        end else if (opcode[10:3] == OP_CBZ_HI) begin
            cls = CLS_CBZ;
        end else if (opcode[10:5] == OP_B_HI) begin
            cls = CLS_B;
        end else if ((opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_ORR)) begin
            cls = CLS_RTYPE;
        end else begin
            cls = CLS_ILLEGAL;
        end
        imm_sel = imm_format(cls);
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle sequencing controller for the LEGv8 core. Steps each
//   instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath enables,
//   runs the req/ready memory handshake and supervises it with a timeout
//   that parks the FSM in HALT with a sticky bus_err.
//   Optional feature macro: MC_PERF_CNT_EN adds cycle_cnt/retire_cnt.
//   Ports:
//     clk, reset (async, active high)
//     opcode [10:0] (IR[31:21]), zero (ALU flag), mem_ready
//     mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
//     alu_src, alu_op[1:0], imm_sel[1:0], retire, illegal, bus_err
//     cycle_cnt, retire_cnt [CNT_W-1:0] (MC_PERF_CNT_EN only)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_sel,
    output logic        retire,
    output logic        illegal,
    output logic        bus_err
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 32'sd1);

    mc_state_e    state_r;
    instr_class_e class_r;
    logic [1:0]   imm_sel_r;
    logic         bus_err_r;
    logic [TO_W-1:0] wait_cnt_r;

    instr_class_e dec_class_s;
    logic [1:0]   dec_imm_s;
    logic         req_pending_s;
    logic         wait_expired_s;

    opcode_classifier u_classifier (
        .opcode  (opcode),
        .cls     (dec_class_s),
        .imm_sel (dec_imm_s)
    );

    // A request is pending when the state requests and memory has not answered
    always_comb begin
        req_pending_s  = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;
        wait_expired_s = req_pending_s && (wait_cnt_r == TO_W'(MEM_TIMEOUT - 32'sd1));
    end

    // Wait counter: counts unanswered request cycles, zero otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {TO_W{1'b0}};
        end else if (req_pending_s) begin
            wait_cnt_r <= wait_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Main sequencer: state, latched class/immediate format and sticky bus error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            class_r   <= CLS_ILLEGAL;
            imm_sel_r <= IMM_NONE;
            bus_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_r <= ST_DECODE;
                    end else if (wait_expired_s) begin
                        state_r   <= ST_HALT;
                        bus_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    class_r   <= dec_class_s;
                    imm_sel_r <= dec_imm_s;
                    state_r   <= (dec_class_s == CLS_ILLEGAL) ? ST_FETCH : ST_EXEC;
                end
                ST_EXEC: begin
                    case (class_r)
                        CLS_LDUR, CLS_STUR: state_r <= ST_MEM;
                        CLS_RTYPE:          state_r <= ST_WB;
                        default:            state_r <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state_r <= (class_r == CLS_STUR) ? ST_FETCH : ST_WB;
                    end else if (wait_expired_s) begin
                        state_r   <= ST_HALT;
                        bus_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_WB:   state_r <= ST_FETCH;
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_HALT;
            endcase
        end
    end

    // Output decode from state and latched class; handshake-completion
    // strobes follow mem_ready in the same cycle. Reset forces everything
    // low because the held state already reads FETCH.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        retire     = 1'b0;
        illegal    = 1'b0;
        if (reset) begin
            mem_req = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                ST_DECODE: begin
                    illegal  = (dec_class_s == CLS_ILLEGAL);
                    pc_write = (dec_class_s == CLS_ILLEGAL);
                end
                ST_EXEC: begin
                    case (class_r)
                        CLS_LDUR, CLS_STUR: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_ADD;
                        end
                        CLS_RTYPE: alu_op = ALU_RTYPE;
                        CLS_CBZ: begin
                            alu_op   = ALU_PASSB;
                            pc_write = 1'b1;
                            pc_src   = zero;
                            retire   = 1'b1;
                        end
                        CLS_B: begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                            retire   = 1'b1;
                        end
                        default: alu_op = ALU_ADD;
                    endcase
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    mem_we   = (class_r == CLS_STUR);
                    pc_write = mem_ready && (class_r == CLS_STUR);
                    retire   = mem_ready && (class_r == CLS_STUR);
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (class_r == CLS_LDUR);
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign imm_sel = imm_sel_r;
    assign bus_err = bus_err_r;

`ifdef MC_PERF_CNT_EN
    // Performance counters: active cycles outside HALT and retired instructions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= {CNT_W{1'b0}};
            retire_cnt <= {CNT_W{1'b0}};
        end else begin
            if (state_r != ST_HALT) begin
                cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cycle_cnt <= cycle_cnt;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retire_cnt <= retire_cnt;
            end
        end
    end
`endif

endmodule
